// File: rtl/generic_mem_pkg.sv
// Shared types and constants for the generic_mem sharing logic.
package generic_mem_pkg;

  typedef enum logic [0:0] {
    ST_INIT,
    ST_RUN
  } state_e;

  // Cycles from accept to read data on the requester side.
  localparam int unsigned MEM_RD_LATENCY = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr_i wins, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int unsigned NREQ = 2,
  localparam int unsigned IW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o
);

  always_comb begin
    int j;
    gnt_o = '0;
    idx_o = '0;
    j     = 0;
    // Walk from the farthest offset back to the pointer so the closest hit is written last.
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      j = (int'(ptr_i) + k) % int'(NREQ);
      if (req_i[j]) begin
        gnt_o    = '0;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/generic_mem_arbiter.sv
// Shares one generic_mem between NREQ requesters: zero-fills after reset, then issues
// one round-robin-arbitrated read or write per cycle and routes read data back by tag.
module generic_mem_arbiter
  import generic_mem_pkg::*;
#(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned WIDTH  = 32,
  localparam int unsigned AWIDTH = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ-1:0]        req_we,
  input  logic [NREQ*AWIDTH-1:0] req_addr,
  input  logic [NREQ*WIDTH-1:0]  req_wdata,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [WIDTH-1:0]       rsp_rdata,
  output logic                   init_done,
  output logic                   mem_wr_en,
  output logic [AWIDTH-1:0]      mem_wr_addr,
  output logic [WIDTH-1:0]       mem_wr_data,
  output logic                   mem_rd_en,
  output logic [AWIDTH-1:0]      mem_rd_addr,
  input  logic [WIDTH-1:0]       mem_rd_data
);

  localparam int unsigned IW = $clog2(NREQ);

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] init_addr_q, init_addr_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic              init_done_q, init_done_d;
  logic              wr_en_q, wr_en_d;
  logic [AWIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0]  wr_data_q, wr_data_d;
  logic              rd_en_q, rd_en_d;
  logic [AWIDTH-1:0] rd_addr_q, rd_addr_d;
  // One-hot requester tag per stage; the last stage is the response strobe.
  logic [NREQ-1:0]   tag_q [MEM_RD_LATENCY];
  logic [NREQ-1:0]   tag_d [MEM_RD_LATENCY];

  logic [NREQ-1:0]   gnt;
  logic [IW-1:0]     gnt_idx;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr_arbiter (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    rr_ptr_d    = rr_ptr_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rd_en_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    req_ready   = '0;
    tag_d[0]    = '0;
    for (int s = 1; s < int'(MEM_RD_LATENCY); s++) begin
      tag_d[s] = tag_q[s-1];
    end

    unique case (state_q)
      ST_INIT: begin
        wr_en_d     = 1'b1;
        wr_addr_d   = init_addr_q;
        wr_data_d   = '0;
        init_addr_d = init_addr_q + AWIDTH'(1);
        if (init_addr_q == AWIDTH'(DEPTH - 1)) begin
          state_d     = ST_RUN;
          init_addr_d = '0;
        end
      end
      ST_RUN: begin
        req_ready = gnt;
        if (|gnt) begin
          rr_ptr_d = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
          if (req_we[gnt_idx]) begin
            wr_en_d   = 1'b1;
            wr_addr_d = req_addr[gnt_idx*AWIDTH +: AWIDTH];
            wr_data_d = req_wdata[gnt_idx*WIDTH +: WIDTH];
          end else begin
            rd_en_d   = 1'b1;
            rd_addr_d = req_addr[gnt_idx*AWIDTH +: AWIDTH];
            tag_d[0]  = gnt;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase

    init_done_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
      rr_ptr_q    <= '0;
      init_done_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      tag_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      rr_ptr_q    <= rr_ptr_d;
      init_done_q <= init_done_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      tag_q       <= tag_d;
    end
  end

  assign init_done   = init_done_q;
  assign mem_wr_en   = wr_en_q;
  assign mem_wr_addr = wr_addr_q;
  assign mem_wr_data = wr_data_q;
  assign mem_rd_en   = rd_en_q;
  assign mem_rd_addr = rd_addr_q;
  assign rsp_valid   = tag_q[MEM_RD_LATENCY-1];
  assign rsp_rdata   = mem_rd_data;

endmodule

// File: tb/tb_generic_mem_arbiter.sv
// Directed bench for generic_mem_arbiter with a transaction-level reference model and memory stub.
module tb_generic_mem_arbiter;
  import generic_mem_pkg::*;

  localparam int unsigned NREQ  = 2;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned AW    = 3;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_we;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*WIDTH-1:0] req_wdata;
  logic [NREQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]      rsp_rdata;
  logic                  init_done;
  logic                  mem_wr_en;
  logic [AW-1:0]         mem_wr_addr;
  logic [WIDTH-1:0]      mem_wr_data;
  logic                  mem_rd_en;
  logic [AW-1:0]         mem_rd_addr;
  logic [WIDTH-1:0]      mem_rd_data;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;

  always #5 clk = ~clk;

  generic_mem_arbiter #(
    .NREQ  (NREQ),
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .init_done   (init_done),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data)
  );

  // Memory stub with registered read; filled with junk while in reset so zero-fill is observable.
  logic [WIDTH-1:0] env_mem [DEPTH];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) env_mem[i] <= 32'hBAD0_0000 + 32'(i);
    end else begin
      if (mem_wr_en) env_mem[mem_wr_addr] <= mem_wr_data;
      if (mem_rd_en) mem_rd_data <= env_mem[mem_rd_addr];
    end
  end

  // Cycle number since reset release; cycle 0 precedes the first rising edge.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: schedule of expected port activity and responses keyed by cycle.
  int               m_ptr;
  logic [WIDTH-1:0] ref_mem [DEPTH];
  int               ev_kind [int];
  int               ev_addr [int];
  logic [WIDTH-1:0] ev_data [int];
  int               rsp_id  [int];
  logic [WIDTH-1:0] rsp_dat [int];

  always @(negedge clk) begin
    int               c, g, a;
    logic [NREQ-1:0]  exp_ready, exp_rv;
    logic             e_wr, e_rd;
    int               e_wa, e_ra;
    logic [WIDTH-1:0] e_wd;
    if (rst) begin
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_init_done", 64'(init_done), 64'd0);
      chk("rst_mem_wr_en", 64'(mem_wr_en), 64'd0);
      chk("rst_mem_rd_en", 64'(mem_rd_en), 64'd0);
      m_ptr = 0;
      ev_kind.delete(); ev_addr.delete(); ev_data.delete();
      rsp_id.delete(); rsp_dat.delete();
      for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
    end else begin
      c = cyc;
      g = -1;
      exp_ready = '0;
      if (c >= int'(DEPTH)) begin
        for (int k = 0; k < int'(NREQ); k++) begin
          if (g < 0 && req_valid[(m_ptr + k) % int'(NREQ)]) g = (m_ptr + k) % int'(NREQ);
        end
      end
      if (g >= 0) exp_ready[g] = 1'b1;

      e_wr = 1'b0; e_rd = 1'b0; e_wa = 0; e_ra = 0; e_wd = '0;
      if (c >= 1 && c <= int'(DEPTH)) begin
        e_wr = 1'b1;
        e_wa = c - 1;
      end else if (ev_kind.exists(c)) begin
        if (ev_kind[c] == 1) begin
          e_wr = 1'b1; e_wa = ev_addr[c]; e_wd = ev_data[c];
        end else begin
          e_rd = 1'b1; e_ra = ev_addr[c];
        end
      end
      exp_rv = rsp_id.exists(c) ? NREQ'(1 << rsp_id[c]) : '0;

      chk("m_req_ready", 64'(req_ready), 64'(exp_ready));
      chk("m_init_done", 64'(init_done), 64'(c >= int'(DEPTH)));
      chk("m_mem_wr_en", 64'(mem_wr_en), 64'(e_wr));
      if (e_wr) begin
        chk("m_mem_wr_addr", 64'(mem_wr_addr), 64'(e_wa));
        chk("m_mem_wr_data", 64'(mem_wr_data), 64'(e_wd));
      end
      chk("m_mem_rd_en", 64'(mem_rd_en), 64'(e_rd));
      if (e_rd) chk("m_mem_rd_addr", 64'(mem_rd_addr), 64'(e_ra));
      chk("m_rsp_valid", 64'(rsp_valid), 64'(exp_rv));
      if (rsp_id.exists(c)) chk("m_rsp_rdata", 64'(rsp_rdata), 64'(rsp_dat[c]));

      if (g >= 0) begin
        a = int'(req_addr[g*AW +: AW]);
        ev_addr[c+1] = a;
        if (req_we[g]) begin
          ev_kind[c+1] = 1;
          ev_data[c+1] = req_wdata[g*WIDTH +: WIDTH];
          ref_mem[a]   = req_wdata[g*WIDTH +: WIDTH];
        end else begin
          ev_kind[c+1] = 2;
          rsp_id[c+int'(MEM_RD_LATENCY)]  = g;
          rsp_dat[c+int'(MEM_RD_LATENCY)] = ref_mem[a];
        end
        m_ptr = (g + 1) % int'(NREQ);
      end
      if (ev_kind.exists(c)) ev_kind.delete(c);
      if (rsp_id.exists(c)) rsp_id.delete(c);
    end
  end

  task automatic drive(input logic [1:0] v, input logic [1:0] we, input logic [AW-1:0] a0,
                       input logic [AW-1:0] a1, input logic [31:0] d0, input logic [31:0] d1);
    @(posedge clk);
    #1;
    req_valid = v;
    req_we    = we;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
    @(negedge clk);
  endtask

  task automatic idle();
    drive(2'b00, 2'b00, '0, '0, '0, '0);
  endtask

  task automatic set_rst(input logic val);
    @(posedge clk);
    #1;
    rst       = val;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    @(negedge clk);
  endtask

  logic [1:0] g3 [6];
  logic [1:0] r3 [6];
  logic [1:0] exp_g3 [4];

  initial begin
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    exp_g3    = '{2'b01, 2'b10, 2'b01, 2'b10};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t1_c0_wr_en", 64'(mem_wr_en), 64'd0);

    // Zero-fill: addresses 0..7 on cycles 1..8.
    for (int k = 1; k <= 7; k++) begin
      idle();
      chk("t1_wr_addr", 64'(mem_wr_addr), 64'(k - 1));
      chk("t1_ready", 64'(req_ready), 64'd0);
      chk("t1_init_done", 64'(init_done), 64'd0);
    end

    // Write then read-back by requester 0.
    drive(2'b01, 2'b01, 3'd3, 3'd0, 32'hDEADBEEF, 32'h0);
    chk("t2_wr_addr7", 64'(mem_wr_addr), 64'd7);
    chk("t2_init_done", 64'(init_done), 64'd1);
    chk("t2_ready_wr", 64'(req_ready), 64'h1);
    drive(2'b01, 2'b00, 3'd3, 3'd0, 32'h0, 32'h0);
    chk("t2_ready_rd", 64'(req_ready), 64'h1);
    chk("t2_wr_data", 64'(mem_wr_data), 64'hDEADBEEF);
    idle();
    chk("t2_rd_en", 64'(mem_rd_en), 64'd1);
    idle();
    chk("t2_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("t2_rsp_rdata", 64'(rsp_rdata), 64'hDEADBEEF);

    // Write by requester 1, read by requester 0 in the next cycle.
    drive(2'b10, 2'b10, 3'd0, 3'd5, 32'h0, 32'h55);
    chk("t4_ready_wr", 64'(req_ready), 64'h2);
    drive(2'b01, 2'b00, 3'd5, 3'd0, 32'h0, 32'h0);
    chk("t4_ready_rd", 64'(req_ready), 64'h1);
    idle();
    idle();
    chk("t4_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("t4_rsp_rdata", 64'(rsp_rdata), 64'h55);

    // Read of a location only touched by the zero-fill.
    drive(2'b10, 2'b00, 3'd0, 3'd6, 32'h0, 32'h0);
    idle();
    idle();
    chk("t5_rsp_valid", 64'(rsp_valid), 64'h2);
    chk("t5_rsp_rdata", 64'(rsp_rdata), 64'h0);

    // Both requesters reading continuously for four cycles.
    for (int k = 0; k < 6; k++) begin
      if (k < 4) drive(2'b11, 2'b00, 3'd1, 3'd2, 32'h0, 32'h0);
      else       idle();
      g3[k] = req_ready;
      r3[k] = rsp_valid;
    end
    for (int k = 0; k < 4; k++) begin
      chk("t3_grant", 64'(g3[k]), 64'(exp_g3[k]));
      chk("t3_rsp", 64'(r3[k+2]), 64'(exp_g3[k]));
    end

    // Reset with a read response outstanding.
    drive(2'b01, 2'b00, 3'd3, 3'd0, 32'h0, 32'h0);
    set_rst(1'b1);
    chk("t6_rst_rsp", 64'(rsp_valid), 64'd0);
    set_rst(1'b0);
    for (int k = 1; k <= 5; k++) begin
      idle();
      chk("t6_no_rsp", 64'(rsp_valid), 64'd0);
      chk("t6_wr_addr", 64'(mem_wr_addr), 64'(k - 1));
    end

    // Reset again in the middle of the zero-fill.
    set_rst(1'b1);
    chk("t6_rst_wr_en", 64'(mem_wr_en), 64'd0);
    set_rst(1'b0);
    for (int k = 1; k <= 8; k++) begin
      idle();
      chk("t6_refill_en", 64'(mem_wr_en), 64'd1);
      chk("t6_refill_addr", 64'(mem_wr_addr), 64'(k - 1));
      chk("t6_refill_done", 64'(init_done), 64'(k == 8));
    end
    drive(2'b10, 2'b00, 3'd0, 3'd3, 32'h0, 32'h0);
    idle();
    idle();
    chk("t6_rd_rsp", 64'(rsp_valid), 64'h2);
    chk("t6_rd_zero", 64'(rsp_rdata), 64'h0);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
